// File: rtl/yuv444_to_yuv422_if.sv
// Pixel bus between a 4:4:4 source and the 4:2:2 converter.
// Carries the input sample, its syncs and the interleaved-chroma result.
interface yuv444_to_yuv422_if #(
    parameter int C_BPC = 8
);
    logic             hs_i;
    logic             vs_i;
    logic             de_i;
    logic [C_BPC-1:0] y_i;
    logic [C_BPC-1:0] u_i;
    logic [C_BPC-1:0] v_i;
    logic [C_BPC-1:0] y_o;
    logic [C_BPC-1:0] c_o;
    logic             csel_o;
    logic             hs_o;
    logic             vs_o;
    logic             de_o;

    modport slave (
        input  hs_i, vs_i, de_i, y_i, u_i, v_i,
        output y_o, c_o, csel_o, hs_o, vs_o, de_o
    );

    modport master (
        output hs_i, vs_i, de_i, y_i, u_i, v_i,
        input  y_o, c_o, csel_o, hs_o, vs_o, de_o
    );
endinterface

// File: rtl/yuv444_to_yuv422.sv
// 4:4:4 to 4:2:2 converter, two-clock latency, Cb on even / Cr on odd pixels.
// Define YUV422_CHROMA_AVG_EN for pairwise chroma averaging instead of decimation.
module yuv444_to_yuv422 #(
    parameter int C_BPC = 8
) (
    input logic clk,
    input logic rst,
    yuv444_to_yuv422_if.slave bus
);
    localparam logic [C_BPC-1:0] Y_BLANK = C_BPC'(16 << (C_BPC - 8));
    localparam logic [C_BPC-1:0] C_BLANK = C_BPC'(128 << (C_BPC - 8));

    logic             phase;
    logic             de_prev;
    logic             ph_in;
    logic [C_BPC-1:0] s1_y;
    logic [C_BPC-1:0] s1_u;
    logic [C_BPC-1:0] s1_v;
    logic             s1_de;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_ph;
    logic [C_BPC-1:0] hv;
    logic [C_BPC-1:0] c_nxt;

    // A pixel following a blank cycle always starts a new pair.
    assign ph_in = de_prev ? phase : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 1'b0;
            de_prev <= 1'b0;
            s1_y    <= '0;
            s1_u    <= '0;
            s1_v    <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_ph   <= 1'b0;
            hv      <= '0;
        end else begin
            de_prev <= bus.de_i;
            if (bus.de_i)
                phase <= ~ph_in;
            s1_y  <= bus.y_i;
            s1_u  <= bus.u_i;
            s1_v  <= bus.v_i;
            s1_de <= bus.de_i;
            s1_hs <= bus.hs_i;
            s1_vs <= bus.vs_i;
            s1_ph <= ph_in;
            if (s1_de && !s1_ph)
                hv <= s1_v;
        end
    end

`ifdef YUV422_CHROMA_AVG_EN
    logic [C_BPC:0] sum_u;
    logic [C_BPC:0] sum_v;

    assign sum_u = {1'b0, s1_u} + {1'b0, bus.u_i} + 1'b1;
    assign sum_v = {1'b0, hv} + {1'b0, s1_v} + 1'b1;

    // Last even pixel of a line has no partner: keep its own Cb.
    always_comb begin
        c_nxt = s1_u;
        if (s1_ph)
            c_nxt = sum_v[C_BPC:1];
        else if (bus.de_i)
            c_nxt = sum_u[C_BPC:1];
    end
`else
    always_comb begin
        c_nxt = s1_u;
        if (s1_ph)
            c_nxt = hv;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y_o    <= '0;
            bus.c_o    <= '0;
            bus.csel_o <= 1'b0;
            bus.hs_o   <= 1'b0;
            bus.vs_o   <= 1'b0;
            bus.de_o   <= 1'b0;
        end else begin
            bus.hs_o <= s1_hs;
            bus.vs_o <= s1_vs;
            bus.de_o <= s1_de;
            if (s1_de) begin
                bus.y_o    <= s1_y;
                bus.c_o    <= c_nxt;
                bus.csel_o <= s1_ph;
            end else begin
                bus.y_o    <= Y_BLANK;
                bus.c_o    <= C_BLANK;
                bus.csel_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_yuv444_to_yuv422.sv
// Directed bench for yuv444_to_yuv422 with a per-cycle expected-output queue.
// Expected chroma follows YUV422_CHROMA_AVG_EN the same way as the build.
module tb_yuv444_to_yuv422;
    localparam int C_BPC = 8;
`ifdef YUV422_CHROMA_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] y;
        logic [7:0] c;
        logic       cs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    int   uu[8];
    int   vv[8];
    int   yy[8];

    yuv444_to_yuv422_if #(.C_BPC(C_BPC)) bus ();

    yuv444_to_yuv422 #(.C_BPC(C_BPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input exp_t exp_v);
        exp_t obs;
        obs = '{bus.hs_o, bus.vs_o, bus.de_o, bus.y_o, bus.c_o, bus.csel_o};
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive at negedge, queue the expected result, check after posedge.
    task automatic cyc(input string tag, input logic r, input logic hs,
                       input logic vs, input logic de, input int y,
                       input int u, input int v, input int ec,
                       input logic ecs);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.hs_i  = hs;
        bus.vs_i  = vs;
        bus.de_i  = de;
        bus.y_i   = 8'(y);
        bus.u_i   = 8'(u);
        bus.v_i   = 8'(v);
        if (r) begin
            sbq.delete();
        end else begin
            e.hs = hs;
            e.vs = vs;
            e.de = de;
            e.y  = de ? 8'(y) : 8'd16;
            e.c  = de ? 8'(ec) : 8'd128;
            e.cs = de ? ecs : 1'b0;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r)
            check({tag, "_rst"}, '0);
        else if (sbq.size() >= 2)
            check(tag, sbq.pop_front());
    endtask

    task automatic idle(input string tag, input logic hs, input logic vs);
        cyc(tag, 1'b0, hs, vs, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic line(input string tag, input int n);
        int ec;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0)
                ec = (AVG && i + 1 < n) ? (uu[i] + uu[i+1] + 1) / 2 : uu[i];
            else
                ec = AVG ? (vv[i-1] + vv[i] + 1) / 2 : vv[i-1];
            cyc(tag, 1'b0, 1'b0, 1'b1, 1'b1, yy[i], uu[i], vv[i], ec,
                1'(i % 2));
        end
    endtask

    initial begin
        bus.hs_i = 1'b0;
        bus.vs_i = 1'b0;
        bus.de_i = 1'b0;
        bus.y_i  = '0;
        bus.u_i  = '0;
        bus.v_i  = '0;

        // Reset with active pixels present: outputs stay 0.
        for (int i = 0; i < 3; i++)
            cyc("reset", 1'b1, 1'b1, 1'b1, 1'b1, 77, 33, 44, 0, 1'b0);

        // First pixel after release is a line start.
        uu = '{10, 20, 30, 40, 0, 0, 0, 0};
        vv = '{50, 60, 70, 80, 0, 0, 0, 0};
        yy = '{21, 22, 23, 24, 0, 0, 0, 0};
        line("line4", 4);
        idle("gap", 1'b0, 1'b0);
        idle("gap", 1'b0, 1'b0);

        // Odd-length line followed by a single blank cycle.
        uu = '{100, 102, 200, 0, 0, 0, 0, 0};
        vv = '{110, 120, 130, 0, 0, 0, 0, 0};
        yy = '{31, 32, 33, 0, 0, 0, 0, 0};
        line("line3", 3);
        idle("gap1", 1'b1, 1'b0);
        uu = '{1, 3, 5, 7, 0, 0, 0, 0};
        vv = '{9, 11, 13, 15, 0, 0, 0, 0};
        yy = '{41, 42, 43, 44, 0, 0, 0, 0};
        line("b2b", 4);

        // Blanking with toggling syncs.
        idle("sync", 1'b1, 1'b0);
        idle("sync", 1'b0, 1'b1);
        idle("sync", 1'b1, 1'b1);
        idle("sync", 1'b0, 1'b0);
        idle("sync", 1'b1, 1'b0);

        // Full-scale pair must not wrap.
        uu = '{255, 255, 0, 0, 0, 0, 0, 0};
        vv = '{255, 255, 0, 0, 0, 0, 0, 0};
        yy = '{235, 235, 0, 0, 0, 0, 0, 0};
        line("max", 2);
        idle("gap", 1'b0, 1'b0);
        idle("gap", 1'b0, 1'b0);

        // Mid-line reset discards the partial line.
        cyc("pre", 1'b0, 1'b0, 1'b0, 1'b1, 50, 60, 70, 0, 1'b0);
        cyc("rst2", 1'b1, 1'b0, 1'b0, 1'b1, 51, 61, 71, 0, 1'b0);
        cyc("rst2", 1'b1, 1'b0, 1'b0, 1'b1, 52, 62, 72, 0, 1'b0);
        uu = '{90, 91, 92, 93, 94, 95, 0, 0};
        vv = '{80, 81, 82, 83, 84, 85, 0, 0};
        yy = '{60, 61, 62, 63, 64, 65, 0, 0};
        line("after", 6);
        idle("tail", 1'b0, 1'b0);
        idle("tail", 1'b0, 1'b0);
        idle("tail", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
